ulpi_reg_read: RTL and testbench

Link-side ULPI immediate register read initiator for the USB3300 sniffer. On a `PrR` request it issues the Register Read TXCMD, completes the bus turnaround handshake, captures the byte the PHY returns and hands it to the control logic. It sits beside the register-write block on the same ULPI bus; the top-level mux selects its `DATA_O` while `busy` is high.

---
 rtl/ulpi_reg_read_if.sv | 24 ++
 rtl/ulpi_reg_read.sv | 119 +++++++++++
 tb/tb_ulpi_reg_read.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_reg_read_if.sv
// Signal bundle for the ULPI register-read initiator: control request/response plus the ULPI bus.
// slave = the initiator block, master = control logic / PHY side.
interface ulpi_reg_read_if;
   logic       PrR;
   logic [5:0] ADDR;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] REG_VAL;
   logic       DIR;
   logic       NXT;
   logic [7:0] DATA_I;
   logic [7:0] DATA_O;

   modport slave (
      input  PrR, ADDR, DIR, NXT, DATA_I,
      output busy, done, err, REG_VAL, DATA_O
   );

   modport master (
      output PrR, ADDR, DIR, NXT, DATA_I,
      input  busy, done, err, REG_VAL, DATA_O
   );
endinterface

// File: rtl/ulpi_reg_read.sv
// ULPI immediate register read initiator: TXCMD, turnaround, single-byte capture.
// Optional TXCMD/TURN timeout is enabled by defining ULPI_RR_TIMEOUT_EN.
module ulpi_reg_read #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           clk_ULPI,
   input  logic           rst,
   ulpi_reg_read_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TXCMD = 3'd1,
      S_TURN  = 3'd2,
      S_DATA  = 3'd3,
      S_END   = 3'd4,
      S_ABORT = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] data_o_q, data_o_d;
   logic [7:0] reg_val_q, reg_val_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef ULPI_RR_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter restarts on every entry to TXCMD, so an ABORT retry gets a fresh budget.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == S_TXCMD && state_q != S_TXCMD)
         cnt_d = '0;
      else if (state_q == S_TXCMD || state_q == S_TURN)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_ULPI or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign timeout = (state_q == S_TXCMD || state_q == S_TURN) &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         data_o_q  <= 8'h00;
         reg_val_q <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_o_q  <= data_o_d;
         reg_val_q <= reg_val_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state; DIR beats NXT in TXCMD because the PHY owns the bus once it raises DIR.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.PrR) begin
               state_d = S_TXCMD;
               addr_d  = bus.ADDR;
            end
         end
         S_TXCMD: begin
            if (timeout)      state_d = S_IDLE;
            else if (bus.DIR) state_d = S_ABORT;
            else if (bus.NXT) state_d = S_TURN;
         end
         S_TURN: begin
            if (timeout)      state_d = S_IDLE;
            else if (bus.DIR) state_d = S_DATA;
         end
         S_DATA:  state_d = S_END;
         S_END:   if (!bus.DIR) state_d = S_IDLE;
         S_ABORT: if (!bus.DIR) state_d = S_TXCMD;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are derived from the next state so DATA_O tracks TXCMD with no extra cycle of lag.
   always_comb begin
      data_o_d  = (state_d == S_TXCMD) ? {2'b11, addr_d} : 8'h00;
      done_d    = (state_q == S_DATA);
      err_d     = timeout;
      reg_val_d = (state_q == S_DATA) ? bus.DATA_I : reg_val_q;
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.REG_VAL = reg_val_q;
   assign bus.DATA_O  = data_o_q;

endmodule

// File: tb/tb_ulpi_reg_read.sv
// Directed bench for ulpi_reg_read: PHY responses driven step by step, captured bytes scoreboarded.
// The timeout scenario follows whichever ULPI_RR_TIMEOUT_EN build is compiled.
module tb_ulpi_reg_read;

   logic clk_ULPI = 1'b0;
   logic rst      = 1'b0;
   int   errors   = 0;
   int   checks   = 0;
   int   done_cnt = 0;
   int   err_cnt  = 0;
   logic [7:0] sb[$];

   ulpi_reg_read_if bus ();

   ulpi_reg_read #(.TIMEOUT_CYCLES(16)) dut (
      .clk_ULPI (clk_ULPI),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 clk_ULPI = ~clk_ULPI;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the next byte the PHY model returned.
   always @(negedge clk_ULPI) begin
      if (rst && bus.done) begin
         done_cnt++;
         if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
         else                check("reg_val", {24'd0, bus.REG_VAL}, {24'd0, sb.pop_front()});
      end
      if (rst && bus.err) err_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk_ULPI);
      #1;
   endtask

   task automatic start(input logic [5:0] addr);
      bus.ADDR = addr;
      bus.PrR  = 1'b1;
      cyc();
      bus.PrR  = 1'b0;
   endtask

   // Entered in a TXCMD cycle; runs the nominal NXT / DIR / data / release sequence.
   task automatic complete(input string tag, input logic [5:0] addr, input logic [7:0] val);
      check({tag, "_txcmd"}, {24'd0, bus.DATA_O}, {24'd0, 2'b11, addr});
      bus.NXT = 1'b1;
      cyc();
      bus.NXT = 1'b0;
      check({tag, "_turn_dout"}, {24'd0, bus.DATA_O}, 32'h0);
      bus.DIR    = 1'b1;
      bus.DATA_I = 8'hEE;
      cyc();
      bus.DATA_I = val;
      sb.push_back(val);
      cyc();
      check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      check({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd1);
      bus.DIR    = 1'b0;
      bus.DATA_I = 8'h00;
      cyc();
      check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      logic ok_busy;
      logic ok_dout;
      bus.PrR    = 1'b0;
      bus.ADDR   = 6'h00;
      bus.DIR    = 1'b0;
      bus.NXT    = 1'b0;
      bus.DATA_I = 8'h00;

      // Reset state
      #12;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_regval", {24'd0, bus.REG_VAL}, 32'h0);
      check("rst_dout", {24'd0, bus.DATA_O}, 32'h0);
      cyc();
      rst = 1'b1;
      cyc();

      // Nominal read: CA for two cycles, done at n+5
      start(6'h0A);
      check("nom_busy", {31'd0, bus.busy}, 32'd1);
      check("nom_dout1", {24'd0, bus.DATA_O}, 32'hCA);
      cyc();
      complete("nom", 6'h0A, 8'h41);
      check("nom_done_cnt", done_cnt, 32'd1);

      // Ignored request while busy
      start(6'h0A);
      bus.ADDR = 6'h15;
      bus.PrR  = 1'b1;
      cyc();
      bus.PrR  = 1'b0;
      complete("ign", 6'h0A, 8'h5A);
      cyc();
      check("ign_no_second", {31'd0, bus.busy}, 32'd0);
      check("ign_dout_idle", {24'd0, bus.DATA_O}, 32'h0);
      check("ign_done_cnt", done_cnt, 32'd2);

      // Abort and retry: DIR for 4 cycles with RXCMD bytes
      start(6'h0A);
      bus.DIR    = 1'b1;
      bus.DATA_I = 8'h1B;
      ok_dout    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (bus.DATA_O !== 8'h00 || bus.busy !== 1'b1) ok_dout = 1'b0;
         bus.DATA_I = 8'h1B + 8'(i);
      end
      check("abort_dout_zero", {31'd0, ok_dout}, 32'd1);
      check("abort_regval_held", {24'd0, bus.REG_VAL}, 32'h5A);
      bus.DIR    = 1'b0;
      bus.DATA_I = 8'h00;
      cyc();
      complete("abort", 6'h0A, 8'h77);
      check("abort_done_cnt", done_cnt, 32'd3);

      // NXT and DIR together in TXCMD must abort, not turn around
      start(6'h2C);
      bus.NXT = 1'b1;
      bus.DIR = 1'b1;
      cyc();
      check("both_dout", {24'd0, bus.DATA_O}, 32'h0);
      bus.NXT = 1'b0;
      bus.DIR = 1'b0;
      cyc();
      complete("both", 6'h2C, 8'h96);

      // Asynchronous reset while in TURN
      start(6'h0A);
      bus.NXT = 1'b1;
      cyc();
      bus.NXT = 1'b0;
      bus.DIR = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_regval", {24'd0, bus.REG_VAL}, 32'h0);
      check("arst_dout", {24'd0, bus.DATA_O}, 32'h0);
      check("arst_done", {31'd0, bus.done}, 32'd0);
      cyc();
      cyc();
      bus.DIR = 1'b0;
      rst = 1'b1;
      cyc();
      check("arst_no_done", done_cnt, 32'd4);
      start(6'h0A);
      complete("post_rst", 6'h0A, 8'hC3);

      // Timeout behaviour
      start(6'h0A);
`ifdef ULPI_RR_TIMEOUT_EN
      ok_busy = 1'b1;
      for (int i = 1; i < 16; i++) begin
         if (bus.busy !== 1'b1 || bus.err !== 1'b0) ok_busy = 1'b0;
         cyc();
      end
      check("to_wait", {31'd0, ok_busy}, 32'd1);
      check("to_busy16", {31'd0, bus.busy}, 32'd1);
      cyc();
      check("to_err", {31'd0, bus.err}, 32'd1);
      check("to_busy_low", {31'd0, bus.busy}, 32'd0);
      check("to_dout", {24'd0, bus.DATA_O}, 32'h0);
      check("to_regval", {24'd0, bus.REG_VAL}, 32'hC3);
      cyc();
      check("to_err_pulse", {31'd0, bus.err}, 32'd0);
`else
      ok_busy = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         if (bus.busy !== 1'b1 || bus.err !== 1'b0) ok_busy = 1'b0;
         cyc();
      end
      check("nto_busy_held", {31'd0, ok_busy}, 32'd1);
      check("nto_err_cnt", err_cnt, 32'd0);
      check("nto_regval", {24'd0, bus.REG_VAL}, 32'hC3);
      #2;
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      check("nto_recover", {31'd0, bus.busy}, 32'd0);
`endif
      check("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
